block_reducer: RTL and testbench



---
 rtl/block_reducer_if.sv | 34 +++
 rtl/block_reducer.sv | 142 ++++++++++++++
 tb/tb_block_reducer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_reducer_if.sv
// Bus bundle between block_reducer and its neighbours: multiplier block-read
// port plus the request/result/ack handshake toward the controller.
interface block_reducer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
);
    localparam int unsigned SW = WIDTH + $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            start;
    logic            RDY_mult;
    logic            EN_blockRead;
    logic            VALID_memVal;
    logic [WIDTH-1:0] memVal_data;
    logic [SW-1:0]   sum;
    logic [WIDTH-1:0] max_val;
    logic [CW-1:0]   count;
    logic            done;
    logic            err;
    logic [CW-1:0]   mism_cnt;
    logic            ack;

    // Controller / multiplier side
    modport master (
        output start, RDY_mult, VALID_memVal, memVal_data, ack,
        input  EN_blockRead, sum, max_val, count, done, err, mism_cnt
    );

    // Reducer side
    modport slave (
        input  start, RDY_mult, VALID_memVal, memVal_data, ack,
        output EN_blockRead, sum, max_val, count, done, err, mism_cnt
    );
endinterface

// File: rtl/block_reducer.sv
// Requests one block read from the multiplier and reduces the burst to sum/max/count.
// Optional squares checker compiled in with `define BLOCK_REDUCER_CHECK_EN.
module block_reducer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    block_reducer_if.slave  bus
);
    localparam int unsigned SW = WIDTH + $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_REQ,
        S_COLLECT,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic             r_en;
    logic             r_done;
    logic             r_err;
    logic [SW-1:0]    r_sum;
    logic [WIDTH-1:0] r_max;
    logic [CW-1:0]    r_count;
    logic [TW-1:0]    r_idle;

    logic [CW-1:0]    w_count_inc;
    logic [TW-1:0]    w_idle_inc;
    logic             w_last_word;
    logic             w_timeout;
    logic             w_accept;

    assign w_count_inc = r_count + CW'(1);
    assign w_idle_inc  = r_idle + TW'(1);
    assign w_last_word = (w_count_inc == CW'(DEPTH));
    assign w_timeout   = (w_idle_inc == TW'(TIMEOUT));
    assign w_accept    = (r_state == S_COLLECT) && bus.VALID_memVal;

    // Control FSM and reduction datapath; results stay frozen outside REQ/COLLECT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sum   <= '0;
            r_max   <= '0;
            r_count <= '0;
            r_idle  <= '0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (bus.RDY_mult) begin
                        r_state <= S_REQ;
                        r_en    <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_sum   <= '0;
                    r_max   <= '0;
                    r_count <= '0;
                    r_err   <= 1'b0;
                    r_idle  <= '0;
                    r_state <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (bus.VALID_memVal) begin
                        r_sum   <= r_sum + SW'(bus.memVal_data);
                        r_count <= w_count_inc;
                        r_idle  <= '0;
                        if (bus.memVal_data > r_max) begin
                            r_max <= bus.memVal_data;
                        end
                        if (w_last_word) begin
                            r_state <= S_HOLD;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                        end
                    end else begin
                        r_idle <= w_idle_inc;
                        if (w_timeout) begin
                            r_state <= S_HOLD;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BLOCK_REDUCER_CHECK_EN
    logic [CW-1:0]    r_mism;
    logic [WIDTH-1:0] w_expect_sq;

    assign w_expect_sq = WIDTH'(r_count) * WIDTH'(r_count);

    // Word k of the burst should equal k*k (mod 2^WIDTH)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mism <= '0;
        end else if (r_state == S_REQ) begin
            r_mism <= '0;
        end else if (w_accept && (bus.memVal_data != w_expect_sq)) begin
            r_mism <= r_mism + CW'(1);
        end
    end

    assign bus.mism_cnt = r_mism;
`else
    assign bus.mism_cnt = '0;
`endif

    assign bus.EN_blockRead = r_en;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.sum          = r_sum;
    assign bus.max_val      = r_max;
    assign bus.count        = r_count;

endmodule

// File: tb/tb_block_reducer.sv
// Directed scoreboard bench for block_reducer: full, short, gapped, stalled,
// reset-aborted and corrupted bursts plus the done/ack handshake.
module tb_block_reducer;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned TIMEOUT = 8;

    typedef logic [31:0] wq_t[$];
    typedef struct {
        logic [63:0] sum;
        logic [63:0] maxv;
        logic [63:0] cnt;
        logic [63:0] err;
        logic [63:0] mism;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   en_cnt  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    block_reducer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

    block_reducer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.EN_blockRead === 1'b1) en_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic wq_t squares(input int n);
        wq_t q;
        for (int k = 0; k < n; k++) q.push_back(32'(k * k));
        return q;
    endfunction

    function automatic exp_t model(input wq_t w, input bit timed_out);
        exp_t e;
        e.sum  = '0;
        e.maxv = '0;
        e.cnt  = 64'(w.size());
        e.err  = {63'd0, timed_out};
        e.mism = '0;
        for (int k = 0; k < w.size(); k++) begin
            e.sum = e.sum + 64'(w[k]);
            if (64'(w[k]) > e.maxv) e.maxv = 64'(w[k]);
`ifdef BLOCK_REDUCER_CHECK_EN
            if (w[k] != 32'(k * k)) e.mism = e.mism + 64'd1;
`endif
        end
        return e;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_en"},    64'(bus.EN_blockRead), 64'd0);
        check({tag, "_done"},  64'(bus.done),         64'd0);
        check({tag, "_err"},   64'(bus.err),          64'd0);
        check({tag, "_sum"},   64'(bus.sum),          64'd0);
        check({tag, "_max"},   64'(bus.max_val),      64'd0);
        check({tag, "_count"}, 64'(bus.count),        64'd0);
        check({tag, "_mism"},  64'(bus.mism_cnt),     64'd0);
    endtask

    // Pulse start at this negedge and wait (bounded) for the EN_blockRead cycle
    task automatic request(output int lat);
        bus.start = 1'b1;
        lat = 0;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (bus.EN_blockRead !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check("en_seen", 64'(bus.EN_blockRead), 64'd1);
    endtask

    // Called at the negedge inside the REQ cycle; junk on that cycle must be dropped
    task automatic send_words(input wq_t w, input int gap, input bit poke_start);
        bus.VALID_memVal = 1'b1;
        bus.memVal_data  = 32'hDEAD_BEEF;
        for (int k = 0; k < w.size(); k++) begin
            tick();
            bus.VALID_memVal = 1'b1;
            bus.memVal_data  = w[k];
            bus.start        = poke_start && (k == 3 || k == 40);
            if (k != w.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    bus.VALID_memVal = 1'b0;
                    bus.start        = 1'b0;
                end
            end
        end
        tick();
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = '0;
        bus.start        = 1'b0;
    endtask

    task automatic check_results(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_done"},  64'(bus.done),     64'd1);
            check({tag, "_sum"},   64'(bus.sum),      e.sum);
            check({tag, "_max"},   64'(bus.max_val),  e.maxv);
            check({tag, "_count"}, 64'(bus.count),    e.cnt);
            check({tag, "_err"},   64'(bus.err),      e.err);
            check({tag, "_mism"},  64'(bus.mism_cnt), e.mism);
        end
    endtask

    task automatic do_ack(input string tag);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check({tag, "_done_fall"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        wq_t sq64;
        wq_t sq10;
        wq_t w30;
        wq_t wbad;
        int  lat;
        int  en0;
        logic [63:0] held_sum;

        sq64 = squares(64);
        sq10 = squares(10);
        w30  = squares(30);
        wbad = squares(64);
        wbad[5] = 32'd26;

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.RDY_mult     = 1'b0;
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = '0;
        bus.ack          = 1'b0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Full burst, RDY already high: EN two cycles after start
        bus.RDY_mult = 1'b1;
        en0 = en_cnt;
        sb.push_back(model(sq64, 1'b0));
        request(lat);
        check("full_en_latency", 64'(lat), 64'd2);
        send_words(sq64, 0, 1'b0);
        check("full_sum_literal", 64'(bus.sum), 64'd85344);
        check("full_max_literal", 64'(bus.max_val), 64'd3969);
        check_results("full");
        check("full_en_pulses", 64'(en_cnt - en0), 64'd1);

        // Results must hold while ack stays low
        held_sum = 64'(bus.sum);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("hold_done", 64'(bus.done), 64'd1);
            check("hold_sum",  64'(bus.sum),  held_sum);
        end
        // start together with ack in HOLD is dropped
        bus.start = 1'b1;
        do_ack("full");
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("ack_start_dropped", 64'(en_cnt - en0), 64'd1);

        // Short burst ended by timeout; done exactly after the 8th idle cycle
        sb.push_back(model(sq10, 1'b1));
        request(lat);
        send_words(sq10, 0, 1'b0);
        check("short_idle1_done", 64'(bus.done), 64'd0);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("short_idle_done", 64'(bus.done), 64'd0);
        end
        tick();
        check("short_sum_literal", 64'(bus.sum), 64'd285);
        check("short_max_literal", 64'(bus.max_val), 64'd81);
        check_results("short");
        do_ack("short");

        // Gaps of TIMEOUT-1 must not end the burst
        sb.push_back(model(sq64, 1'b0));
        request(lat);
        send_words(sq64, 7, 1'b0);
        check_results("gapped");
        do_ack("gapped");

        // Ready stall with extra starts during COLLECT
        bus.RDY_mult = 1'b0;
        en0 = en_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 10) bus.start = 1'b1;
            else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("stall_no_en", 64'(en_cnt - en0), 64'd0);
        bus.RDY_mult = 1'b1;
        lat = 0;
        tick();
        lat = 1;
        while (bus.EN_blockRead !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check("stall_en_latency", 64'(lat), 64'd1);
        sb.push_back(model(sq64, 1'b0));
        send_words(sq64, 0, 1'b1);
        check_results("stall");
        check("stall_en_pulses", 64'(en_cnt - en0), 64'd1);
        do_ack("stall");
        for (int i = 0; i < 6; i++) tick();
        check("stall_extra_starts", 64'(en_cnt - en0), 64'd1);

        // Reset in the middle of COLLECT discards the partial burst
        request(lat);
        send_words(w30, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_zero("midrst");
        for (int i = 0; i < 12; i++) tick();
        check("midrst_idle_done", 64'(bus.done), 64'd0);
        sb.push_back(model(sq64, 1'b0));
        request(lat);
        send_words(sq64, 0, 1'b0);
        check_results("after_rst");
        do_ack("after_rst");

        // Corrupted word 5 for the squares checker
        sb.push_back(model(wbad, 1'b0));
        request(lat);
        send_words(wbad, 0, 1'b0);
        check("chk_sum_literal", 64'(bus.sum), 64'd85345);
`ifdef BLOCK_REDUCER_CHECK_EN
        check("chk_mism_literal", 64'(bus.mism_cnt), 64'd1);
`else
        check("chk_mism_literal", 64'(bus.mism_cnt), 64'd0);
`endif
        check_results("checker");
        do_ack("checker");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
